// File: rtl/apb_pkg.sv
// Shared definitions for the parametrised APB4 memory slave.
//   apb_state_e : transfer FSM states (idle, wait-state countdown, response)
//   strb_w()    : number of byte lanes for a data width
//   idx_w()     : word-index width for a byte address width and data width
//   addr_err()  : out-of-range / misaligned check for a byte address
// A package cannot see a module's parameters, so the width helpers take them as arguments.
// Module-level STRB_W and IDX_W localparams are derived from these helpers.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } apb_state_e;

  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned idx_w(input int unsigned addr_w, input int unsigned data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

  // Word index at or beyond depth, or any byte-offset bit set.
  // For 8-bit data the offset mask is empty, so alignment never fails.
  function automatic logic addr_err(input logic [31:0]  addr,
                                    input int unsigned  addr_w,
                                    input int unsigned  data_w,
                                    input int unsigned  depth);
    int unsigned lsb;
    logic [31:0] a;
    logic [31:0] idx;
    logic [31:0] off_mask;
    lsb      = $clog2(data_w / 8);
    a        = addr;
    if (addr_w < 32) a = addr & ((32'd1 << addr_w) - 32'd1);
    idx      = a >> lsb;
    off_mask = (32'd1 << lsb) - 32'd1;
    return (idx >= depth) || ((a & off_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/apb_bytemem.sv
// DEPTH x DATA_W storage array with per-byte write enables.
//   clk_i     : clock, writes on rising edge
//   wr_en_i   : commit write this edge
//   wr_idx_i  : word index for writes
//   wr_strb_i : byte-lane enables
//   wr_data_i : write data
//   rd_idx_i  : word index for asynchronous read
//   rd_data_o : read data (0 for an index beyond DEPTH)
// The array is not reset.
module apb_bytemem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 10
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_W/8-1:0]   wr_strb_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_addr;
  logic [AddrW-1:0]  rd_addr;
  logic              wr_in_range;
  logic              rd_in_range;

  // The index may be wider than the array; range checks guard the truncated address.
  assign wr_addr     = wr_idx_i[AddrW-1:0];
  assign rd_addr     = rd_idx_i[AddrW-1:0];
  assign wr_in_range = (32'(wr_idx_i) < DEPTH);
  assign rd_in_range = (32'(rd_idx_i) < DEPTH);

  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_in_range) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wr_strb_i[b]) mem_q[wr_addr][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  assign rd_data_o = rd_in_range ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/apb_mem_slave_p.sv
// Parametrised APB4 memory slave with byte strobes and programmable wait states.
//   PCLK, PRESET       : clock; asynchronous active-high reset
//   PSEL, PENABLE      : APB select / access phase
//   PWRITE, PADDR      : direction and byte address, sampled in the setup cycle only
//   PWDATA, PSTRB      : write data and byte lanes
//   PRDATA             : registered read data, held outside the response cycle
//   PREADY, PSLVERR    : registered completion and error, high only in the response cycle
module apb_mem_slave_p
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDR_W-1:0]        PADDR,
  input  logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W/8-1:0]      PSTRB,
  output logic [DATA_W-1:0]        PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR
);

  localparam int unsigned STRB_W   = strb_w(DATA_W);
  localparam int unsigned LSB_W    = $clog2(STRB_W);
  localparam int unsigned IDX_W    = idx_w(ADDR_W, DATA_W);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  logic              setup;
  logic [IDX_W-1:0]  paddr_idx;
  logic              paddr_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign setup     = PSEL & ~PENABLE;
  assign paddr_idx = PADDR[ADDR_W-1:LSB_W];
  assign paddr_err = addr_err(32'(PADDR), ADDR_W, DATA_W, DEPTH);

  // Write lands on the edge that ends the response cycle, and only if the master
  // is still in a valid access phase (dropping PSEL aborts it).
  assign mem_we = (state_q == StResp) & PSEL & PENABLE & write_q & ~err_q;

  apb_bytemem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i     (PCLK),
    .wr_en_i   (mem_we),
    .wr_idx_i  (idx_q),
    .wr_strb_i (PSTRB),
    .wr_data_i (PWDATA),
    .rd_idx_i  (idx_d),
    .rd_data_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    write_d   = write_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (setup) begin
          idx_d   = paddr_idx;
          err_d   = paddr_err;
          write_d = PWRITE;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered: load them on the edge entering the response cycle.
    if (state_d == StResp) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!write_d) prdata_d = err_d ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      write_q   <= write_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
Parametrised APB4 memory-mapped slave, the next-generation successor to the fixed 32-bit/256-word APB slave.
- Generalises data width, depth and address width, and adds byte strobes (PSTRB) and programmable wait states.
- Asserts PSLVERR for out-of-range and misaligned accesses, and handles aborted transfers.
- Sits behind the APB address decoder/read-data mux as one selectable peripheral.

Parameters:
DATA_W, 32, data bus width; legal values 8, 16, 32.
ADDR_W, 12, PADDR width, byte address.
DEPTH, 256, number of DATA_W words; must be ≤ 2**(ADDR_W-log2(DATA_W/8)).
WAIT_STATES, 0, extra access cycles inserted before PREADY; range 0..15.

Ports:
PCLK  in  1  clock; all state changes on rising edge.
PRESET  in  1  reset; asynchronous, active-high.
PSEL  in  1  slave select from decoder.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1=write, 0=read.
PADDR  in  ADDR_W  byte address.
PWDATA  in  DATA_W  write data.
PSTRB  in  DATA_W/8  write byte lanes.
PRDATA  out  DATA_W  read data, registered.
PREADY  out  1  transfer complete, registered.
PSLVERR  out  1  transfer error, valid only while PREADY=1.

Behaviour:
- Reset is PRESET high, asynchronous: state=IDLE; PRDATA=0, PREADY=0, PSLVERR=0; wait counter=0. Memory array is not reset.
- Word index = PADDR[ADDR_W-1:log2(DATA_W/8)].
- err = (index ≥ DEPTH) | (PADDR low log2(DATA_W/8) bits ≠ 0). For DATA_W=8 the alignment check is void.
- FSM states and transitions:
  - IDLE→SETUP_SEEN path: on PSEL & !PENABLE, latch addr, err and PWRITE.
    - If WAIT_STATES=0, go to RESP.
    - Otherwise go to WAIT with cnt=WAIT_STATES.
  - WAIT: cnt decrements each cycle; at cnt==1 go to RESP.
  - RESP: PREADY=1 for exactly one cycle; next state is IDLE.
- Latency: PREADY is high in access cycle number WAIT_STATES+1 (the first access cycle when WAIT_STATES=0). The transfer is WAIT_STATES+2 cycles total including setup.
- Reads: PRDATA is loaded on the edge entering RESP.
  - Value is mem[index], or 0 if err.
  - PRDATA holds its value outside RESP; it is not cleared.
- Writes: committed on the RESP cycle edge, only if PSEL & PENABLE & PWRITE & !err.
  - Byte lane b is written iff PSTRB[b]=1. PSTRB=0 is a legal no-op write with PSLVERR=0.
  - PSTRB is ignored on reads.
- Error transfers: PSLVERR=1 in the RESP cycle and no memory update. PSLVERR=0 at every other time.
- Abort: if PSEL=0 in WAIT or RESP:
  - go to IDLE next cycle, PREADY=0;
  - no write occurs; PRDATA is unchanged.
- Back-to-back: a setup cycle in the cycle after RESP is accepted with no idle gap.
- Address latch: address and control are sampled in the setup cycle only. Changes during the access phase are ignored; they are a protocol violation with no check.
- Reset mid-transfer: outputs return to reset values immediately. A pending write is dropped and memory is otherwise unchanged.
- PENABLE=1 while in IDLE is ignored; the FSM does not leave IDLE.

Decomposition:
- Shared package apb_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP);
  - localparams STRB_W=DATA_W/8 and IDX_W=ADDR_W-log2(STRB_W);
  - a function computing err from PADDR and DEPTH.
- One sub-module, apb_bytemem: DEPTH×DATA_W array with per-byte write enable.
  - Synchronous write and asynchronous read index.
  - The top module owns the PRDATA register.

Test Plan:
1. DATA_W=32, WAIT_STATES=0: write 0xDEADBEEF to 0x010 with PSTRB=4'hF, then read 0x010 → PREADY high in first access cycle both times, PRDATA=0xDEADBEEF, PSLVERR=0.
2. WAIT_STATES=2: read 0x010 → PREADY low for 2 access cycles, high on the 3rd, PRDATA=0xDEADBEEF; a back-to-back write follows with no gap.
3. Byte strobes: write 0x11223344 to 0x020 with PSTRB=4'b0101 over prior 0xAAAAAAAA → read returns 0xAA22AA44.
4. Errors with DEPTH=256: read 0x400 → PSLVERR=1, PRDATA=0. Write 0x5 to 0x013 (misaligned) → PSLVERR=1, and mem[4] is unchanged on readback.
5. Abort: WAIT_STATES=3, write 0x12345678 to 0x030, drop PSEL after 1 access cycle → PREADY never high, and readback of 0x030 returns its prior value.
6. Reset: assert PRESET asynchronously mid-WAIT → PREADY, PSLVERR and PRDATA go to 0 before the next edge; the FSM accepts a new setup cycle once PRESET is released.
